// File: rtl/alu_writeback_if.sv
// alu_writeback_if: ALU result channel plus register-file write-back channel
interface alu_writeback_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [63:0]           in_result;
  logic                  in_carry;
  logic [1:0]            in_size;
  logic                  in_signed;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [63:0]           wb_data;
  logic [2:0]            wb_flags;
  modport master (
    output in_valid, in_result, in_carry, in_size, in_signed, in_dest, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, wb_flags
  );
  modport slave (
    input  in_valid, in_result, in_carry, in_size, in_signed, in_dest, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, wb_flags
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: extends ALU results to 64b with {C,N,Z} flags and queues them for the register file; ALU_WB_BYPASS_EN adds same-cycle forwarding when empty
module alu_writeback #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  alu_writeback_if.slave bus,
  output logic [3:0]    count,
  output logic [15:0]   stall_cnt
);
  localparam int             PW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0]     DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);
  logic [REG_ADDR_W-1:0] mem_addr  [DEPTH];
  logic [63:0]           mem_data  [DEPTH];
  logic [2:0]            mem_flags [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [63:0]           n_data;
  logic [2:0]            n_flags;
  logic                  n_neg, ext;
  logic                  fifo_valid, bypass, push, pop;
  always_comb begin
    n_neg = bus.in_size == 2'd0 ? bus.in_result[7] :
            bus.in_size == 2'd1 ? bus.in_result[15] :
            bus.in_size == 2'd2 ? bus.in_result[31] : bus.in_result[63];
    ext = bus.in_signed & n_neg;
    n_data = bus.in_size == 2'd0 ? {{56{ext}}, bus.in_result[7:0]} :
             bus.in_size == 2'd1 ? {{48{ext}}, bus.in_result[15:0]} :
             bus.in_size == 2'd2 ? {{32{ext}}, bus.in_result[31:0]} : bus.in_result;
    n_flags = {bus.in_carry, n_neg, n_data == 64'd0};
  end
  assign fifo_valid = count != 4'd0;
`ifdef ALU_WB_BYPASS_EN
  assign bypass = !rst && !fifo_valid && bus.in_valid && bus.wb_ready;
`else
  assign bypass = 1'b0;
`endif
  // in_ready depends only on occupancy so a pop can never open a slot in the same cycle
  assign bus.in_ready = !rst && count < DEPTH_C;
  assign push         = bus.in_valid && bus.in_ready && !bypass;
  assign pop          = fifo_valid && bus.wb_ready;
  assign bus.wb_valid = fifo_valid || bypass;
  assign bus.wb_addr  = bypass ? bus.in_dest : fifo_valid ? mem_addr[rd_ptr]  : '0;
  assign bus.wb_data  = bypass ? n_data      : fifo_valid ? mem_data[rd_ptr]  : '0;
  assign bus.wb_flags = bypass ? n_flags     : fifo_valid ? mem_flags[rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 4'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      stall_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= push && !pop ? count + 4'd1 : pop && !push ? count - 4'd1 : count;
      if (bus.wb_valid && !bus.wb_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= bus.in_dest;
      mem_data[wr_ptr]  <= n_data;
      mem_flags[wr_ptr] <= n_flags;
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: vector table plus scoreboard for alu_writeback
module tb_alu_writeback;
  localparam int AW = 5;
`ifdef ALU_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef struct {
    logic [1:0]    size;
    logic          sgn;
    logic [63:0]   result;
    logic          carry;
    logic [AW-1:0] dest;
    logic [63:0]   exp_data;
    logic [2:0]    exp_flags;
  } vec_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [2:0]    flags;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  count;
  logic [15:0] stall_cnt;
  int          checks = 0;
  int          errors = 0;
  int          exp_stall = 0;
  exp_t        sb[$];
  exp_t        cur;
  vec_t        vecs[16];
  logic [63:0] h_data;
  logic [AW-1:0] h_addr;
  logic [2:0]  h_flags;
  alu_writeback_if #(.REG_ADDR_W(AW)) bus();
  alu_writeback #(.DEPTH(2), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .count(count), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] mask_of(input logic [1:0] s);
    int w;
    w = 8 << s;
    return s == 2'd3 ? '1 : (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] model_data(input logic [1:0] s, input logic sg, input logic [63:0] r);
    logic [63:0] m;
    int w;
    w = 8 << s;
    m = r & mask_of(s);
    return (sg && m[w-1]) ? (m | ~mask_of(s)) : m;
  endfunction
  function automatic logic [2:0] model_flags(input logic [1:0] s, input logic c, input logic [63:0] r);
    logic [63:0] m;
    int w;
    w = 8 << s;
    m = r & mask_of(s);
    return {c, m[w-1], m == 64'd0};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_stall = 0;
    end
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (bus.in_valid && bus.in_ready) sb.push_back(cur);
    if (bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: wb_valid=1 addr=%0d but no entry expected", bus.wb_addr);
      end else begin
        e = sb.pop_front();
        check("wb_addr", 64'(bus.wb_addr), 64'(e.addr));
        check("wb_data", bus.wb_data, e.data);
        check("wb_flags", 64'(bus.wb_flags), 64'(e.flags));
      end
    end
    if (bus.wb_valid && !bus.wb_ready && exp_stall != 65535) exp_stall++;
  end
  task automatic drive(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_size   = v.size;
    bus.in_signed = v.sgn;
    bus.in_result = v.result;
    bus.in_carry  = v.carry;
    bus.in_dest   = v.dest;
    cur = '{v.dest, v.exp_data, v.exp_flags};
  endtask
  task automatic send(input vec_t v);
    drive(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready=0 for 50 cycles, expected 1");
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (count == 4'd0 && !bus.wb_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: count=%0d after 50 cycles, expected 0", count);
  endtask
  initial begin
    vecs[0] = '{2'd0, 1'b1, 64'h1234_5678_9ABC_DE80, 1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FF80, 3'b010};
    vecs[1] = '{2'd0, 1'b0, 64'h1234_5678_9ABC_DE80, 1'b0, 5'd3,  64'h0000_0000_0000_0080, 3'b010};
    vecs[2] = '{2'd1, 1'b0, 64'h0000_0000_DEAD_0000, 1'b1, 5'd5,  64'h0,                   3'b101};
    vecs[3] = '{2'd2, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 5'd7,  64'h0000_0000_7FFF_FFFF, 3'b000};
    vecs[4] = '{2'd2, 1'b1, 64'h0000_0000_8000_0001, 1'b0, 5'd9,  64'hFFFF_FFFF_8000_0001, 3'b010};
    vecs[5] = '{2'd3, 1'b0, 64'h0,                   1'b1, 5'd11, 64'h0,                   3'b101};
    vecs[6] = '{2'd3, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 5'd13, 64'h8000_0000_0000_0000, 3'b010};
    vecs[7] = '{2'd1, 1'b1, 64'h0000_0000_0001_FFFF, 1'b0, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    for (int i = 8; i < 16; i++) begin
      vecs[i].size   = 2'($urandom_range(3, 0));
      vecs[i].sgn    = 1'($urandom);
      vecs[i].result = {$urandom, $urandom};
      vecs[i].carry  = 1'($urandom);
      vecs[i].dest   = AW'($urandom);
      vecs[i].exp_data  = model_data(vecs[i].size, vecs[i].sgn, vecs[i].result);
      vecs[i].exp_flags = model_flags(vecs[i].size, vecs[i].carry, vecs[i].result);
    end
    bus.in_valid = 1'b0; bus.in_size = 2'd0; bus.in_signed = 1'b0; bus.in_result = '0;
    bus.in_carry = 1'b0; bus.in_dest = '0; bus.wb_ready = 1'b0;
    cur = '{'0, '0, '0};
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wb_data", bus.wb_data, 64'd0);
    check("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    check("rst_wb_flags", 64'(bus.wb_flags), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    // latency: same cycle with bypass, next cycle without
    @(posedge clk); #1; bus.wb_ready = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    check("lat_push_cycle_valid", 64'(bus.wb_valid), 64'(BYP));
    check("lat_push_cycle_count", 64'(count), 64'd0);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_next_cycle_valid", 64'(bus.wb_valid), 64'(!BYP));
    check("lat_next_cycle_count", 64'(count), 64'(!BYP));
    wait_empty();
    for (int i = 0; i < 16; i++) send(vecs[i]);
    wait_empty();
    check("sb_drained_table", 64'(sb.size()), 64'd0);
    // backpressure, then release into full-with-pop
    @(posedge clk); #1; bus.wb_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    drive(vecs[4]);
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_count", 64'(count), 64'd2);
    h_data = bus.wb_data; h_addr = bus.wb_addr; h_flags = bus.wb_flags;
    check("full_head_addr", 64'(h_addr), 64'(vecs[2].dest));
    repeat (3) begin
      @(negedge clk);
      check("hold_data", bus.wb_data, h_data);
      check("hold_addr", 64'(bus.wb_addr), 64'(h_addr));
      check("hold_flags", 64'(bus.wb_flags), 64'(h_flags));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1; bus.wb_ready = 1'b1;
    @(negedge clk);
    check("pop_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("pop_full_count", 64'(count), 64'd2);
    @(negedge clk);
    check("after_pop_count", 64'(count), 64'd1);
    check("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk);
    check("push_pop_count", 64'(count), 64'd1);
    wait_empty();
    check("sb_drained_bp", 64'(sb.size()), 64'd0);
    check("stall_after_bp", 64'(stall_cnt), 64'(exp_stall));
    // reset with a full buffer discards everything
    @(posedge clk); #1; bus.wb_ready = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    #1; rst = 1'b1;
    #1;
    check("mid_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_stall", 64'(stall_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; bus.wb_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_no_wb", 64'(bus.wb_valid), 64'd0);
    end
    send(vecs[7]);
    wait_empty();
    check("sb_drained_final", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
